// File: rtl/io_periph_if.sv
// IO bus between the CPU's memory/IO multiplexer and io_periph.
//   io_read / io_write : IO strobes from the control unit
//   addr               : low byte of the IO address
//   wdata              : 24-bit IO write data
//   rdata              : 24-bit IO read data returned by the peripheral
interface io_periph_if;
  logic        io_read;
  logic        io_write;
  logic [7:0]  addr;
  logic [23:0] wdata;
  logic [23:0] rdata;

  modport master (output io_read, io_write, addr, wdata, input  rdata);
  modport slave  (input  io_read, io_write, addr, wdata, output rdata);
endinterface

// File: rtl/io_periph.sv
// Memory-mapped IO peripheral: LED register (0x60, R/W), debounced switches
// (0x70, R), 6-digit hex seven-segment register (0x80, R/W), plus the
// 8-digit common-anode display scanner.
//   clock, reset : CPU clock, synchronous active-high reset
//   bus          : IO bus slave (strobes, addr, wdata in; rdata out)
//   sw_i         : raw asynchronous board switches
//   led_o        : LED drive, active-high
//   seg_an       : digit enables, active-low (digit 0 rightmost)
//   seg_cat      : segments, active-low (bit7 dp, bits 6..0 g..a)
module io_periph #(
  parameter int DEBOUNCE_CYCLES = 20000,
  parameter int SCAN_DIV        = 10000
) (
  input  logic        clock,
  input  logic        reset,
  io_periph_if.slave  bus,
  input  logic [23:0] sw_i,
  output logic [23:0] led_o,
  output logic [7:0]  seg_an,
  output logic [7:0]  seg_cat
);
  localparam int CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int PRE_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(SCAN_DIV - 1);

  localparam logic [7:0] A_LED = 8'h60;
  localparam logic [7:0] A_SW  = 8'h70;
  localparam logic [7:0] A_SEG = 8'h80;

  logic [23:0]      led_q, seg_q, sw_db_q;
  logic [23:0]      s1_q, s2_q, cand_q;
  logic [CNT_W-1:0] cnt_q;
  logic [PRE_W-1:0] pre_q;
  logic [2:0]       idx_q;
  logic [7:0]       an_q, cat_q, an_d, cat_d;
  logic [23:0]      nib_sh;

  function automatic logic [7:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 8'hC0; 4'h1: hex7 = 8'hF9; 4'h2: hex7 = 8'hA4; 4'h3: hex7 = 8'hB0;
      4'h4: hex7 = 8'h99; 4'h5: hex7 = 8'h92; 4'h6: hex7 = 8'h82; 4'h7: hex7 = 8'hF8;
      4'h8: hex7 = 8'h80; 4'h9: hex7 = 8'h90; 4'hA: hex7 = 8'h88; 4'hB: hex7 = 8'h83;
      4'hC: hex7 = 8'hC6; 4'hD: hex7 = 8'hA1; 4'hE: hex7 = 8'h86; default: hex7 = 8'h8E;
    endcase
  endfunction

  // Read mux is combinational from registered state, so a same-cycle
  // read+write returns the pre-write value.
  always_comb begin
    bus.rdata = '0;
    if (bus.io_read) begin
      case (bus.addr)
        A_LED:   bus.rdata = led_q;
        A_SW:    bus.rdata = sw_db_q;
        A_SEG:   bus.rdata = seg_q;
        default: bus.rdata = '0;
      endcase
    end
  end

  // Next display outputs from the current digit index; digits 6 and 7 have
  // no backing nibble and stay blank.
  always_comb begin
    an_d   = 8'hFF;
    cat_d  = 8'hFF;
    nib_sh = seg_q >> {idx_q, 2'b00};
    if (idx_q < 3'd6) begin
      an_d  = ~(8'd1 << idx_q);
      cat_d = hex7(nib_sh[3:0]);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      led_q   <= '0;
      seg_q   <= '0;
      sw_db_q <= '0;
      s1_q    <= '0;
      s2_q    <= '0;
      cand_q  <= '0;
      cnt_q   <= '0;
      pre_q   <= '0;
      idx_q   <= '0;
      an_q    <= 8'hFE;
      cat_q   <= 8'hC0;
    end else begin
      if (bus.io_write) begin
        case (bus.addr)
          A_LED:   led_q <= bus.wdata;
          A_SEG:   seg_q <= bus.wdata;
          default: ;
        endcase
      end

      s1_q <= sw_i;
      s2_q <= s1_q;
      // Whole word debounced together: any bit change restarts the window.
      if (s2_q != cand_q) begin
        cand_q <= s2_q;
        cnt_q  <= '0;
      end else if (cnt_q != CNT_MAX) begin
        cnt_q <= cnt_q + 1'b1;
      end else begin
        sw_db_q <= cand_q;
      end

      if (pre_q == PRE_MAX) begin
        pre_q <= '0;
        idx_q <= idx_q + 3'd1;
      end else begin
        pre_q <= pre_q + 1'b1;
      end

      an_q  <= an_d;
      cat_q <= cat_d;
    end
  end

  assign led_o   = led_q;
  assign seg_an  = an_q;
  assign seg_cat = cat_q;
endmodule

// File: tb/tb_io_periph.sv
module tb_io_periph;
  localparam int D = 8;
  localparam int S = 4;

  logic        clock = 1'b0;
  logic        reset;
  logic [23:0] sw_i;
  logic [23:0] led_o;
  logic [7:0]  seg_an, seg_cat;

  io_periph_if bus ();

  io_periph #(.DEBOUNCE_CYCLES(D), .SCAN_DIV(S)) dut (
    .clock   (clock),
    .reset   (reset),
    .bus     (bus),
    .sw_i    (sw_i),
    .led_o   (led_o),
    .seg_an  (seg_an),
    .seg_cat (seg_cat)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [23:0] m_led, m_seg, m_db;
  logic [7:0]  m_an, m_cat;
  int          m_k;          // edges since reset
  logic [23:0] hist[$];      // values entering the synchroniser, one per edge
  logic [7:0]  HEX[16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                           8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [23:0] exp_rdata();
    if (!bus.io_read) return 24'h0;
    case (bus.addr)
      8'h60:   return m_led;
      8'h70:   return m_db;
      8'h80:   return m_seg;
      default: return 24'h0;
    endcase
  endfunction

  // Advance the model by one rising edge using the inputs about to be sampled.
  task automatic model_edge();
    int          dig;
    logic [23:0] nib;
    bit          ok;
    if (reset) begin
      m_led = 0; m_seg = 0; m_db = 0;
      m_an = 8'hFE; m_cat = 8'hC0; m_k = 0;
      hist.delete();
      // Synchroniser and candidate are all zero, as if zero had been seen
      // for the last three edges.
      repeat (3) hist.push_back(24'h0);
    end else begin
      dig = (m_k / S) % 8;
      if (dig < 6) begin
        m_an  = ~(8'd1 << dig);
        nib   = m_seg >> (4 * dig);
        m_cat = HEX[nib[3:0]];
      end else begin
        m_an  = 8'hFF;
        m_cat = 8'hFF;
      end
      if (bus.io_write && bus.addr == 8'h60) m_led = bus.wdata;
      if (bus.io_write && bus.addr == 8'h80) m_seg = bus.wdata;
      // Accept a value once D+1 consecutive samples, ending two edges ago,
      // agree.
      hist.push_back(sw_i);
      if (hist.size() > D + 3) void'(hist.pop_front());
      if (hist.size() == D + 3) begin
        ok = 1;
        for (int j = 1; j <= D; j++) if (hist[j] !== hist[0]) ok = 0;
        if (ok) m_db = hist[0];
      end
      m_k++;
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge clock);
    #1;
  endtask

  task automatic check_all(input string tag);
    check({tag, ".led"},   {8'h0, led_o},     {8'h0, m_led});
    check({tag, ".an"},    {24'h0, seg_an},   {24'h0, m_an});
    check({tag, ".cat"},   {24'h0, seg_cat},  {24'h0, m_cat});
    check({tag, ".rdata"}, {8'h0, bus.rdata}, {8'h0, exp_rdata()});
  endtask

  task automatic set_bus(input logic rd, input logic wr, input logic [7:0] a, input logic [23:0] wd);
    bus.io_read = rd; bus.io_write = wr; bus.addr = a; bus.wdata = wd;
  endtask

  initial begin
    reset = 1'b1;
    sw_i  = '0;
    set_bus(0, 0, 8'h00, 24'h0);
    #1;
    tick(); tick();
    reset = 1'b0;

    // Reset state
    check("rst.led", {8'h0, led_o}, 32'h0);
    check("rst.an",  {24'h0, seg_an}, 32'hFE);
    check("rst.cat", {24'h0, seg_cat}, 32'hC0);
    set_bus(1, 0, 8'h60, 0); #1; check("rst.rd60", {8'h0, bus.rdata}, 32'h0);
    set_bus(1, 0, 8'h70, 0); #1; check("rst.rd70", {8'h0, bus.rdata}, 32'h0);
    set_bus(1, 0, 8'h80, 0); #1; check("rst.rd80", {8'h0, bus.rdata}, 32'h0);

    // LED write and read-back
    set_bus(0, 1, 8'h60, 24'hA5A5A5); tick();
    check("led.wr", {8'h0, led_o}, 32'hA5A5A5);
    set_bus(1, 0, 8'h60, 0); #1;
    check("led.rd", {8'h0, bus.rdata}, 32'hA5A5A5);
    set_bus(1, 1, 8'h60, 24'h5A5A5A); #1;
    check("rw.pre", {8'h0, bus.rdata}, 32'hA5A5A5);
    tick();
    set_bus(1, 0, 8'h60, 0); #1;
    check("rw.post", {8'h0, bus.rdata}, 32'h5A5A5A);
    check_all("led");

    // Debounce latency: zero through E0+9, value after E0+10
    set_bus(1, 0, 8'h70, 0);
    sw_i = 24'h123456;
    for (int t = 1; t <= 11; t++) begin
      tick();
      check_all("db");
      check("db.lat", {8'h0, bus.rdata}, (t <= 10) ? 32'h0 : 32'h123456);
    end

    // Bounce on bit 0 never survives a full window
    for (int i = 0; i < 60; i++) begin
      if (i % 3 == 0) sw_i = sw_i ^ 24'h1;
      tick();
      check_all("bounce");
      check("bounce.hold", {8'h0, bus.rdata}, 32'h123456);
    end

    // Display scan of 00ABCD
    set_bus(0, 1, 8'h80, 24'h00ABCD); tick();
    set_bus(1, 0, 8'h80, 0);
    for (int i = 0; i < 40; i++) begin
      tick();
      check_all("scan");
    end

    // Unmapped and read-only writes are ignored
    set_bus(0, 1, 8'h90, 24'hFFFFFF); tick();
    set_bus(0, 1, 8'h70, 24'h111111); tick();
    set_bus(0, 0, 8'h00, 0);
    check("ign.led", {8'h0, led_o}, 32'h5A5A5A);
    set_bus(1, 0, 8'h80, 0); #1; check("ign.seg", {8'h0, bus.rdata}, 32'h00ABCD);
    set_bus(1, 0, 8'h70, 0); #1; check("ign.sw",  {8'h0, bus.rdata}, 32'h123456);
    set_bus(1, 0, 8'h90, 0); #1; check("ign.rd90", {8'h0, bus.rdata}, 32'h0);

    // Reset while a debounce is pending (cnt=5), then a full new window
    set_bus(1, 0, 8'h70, 0);
    sw_i = 24'h000F00;
    repeat (8) tick();
    reset = 1'b1; tick();
    reset = 1'b0;
    check_all("mrst");
    for (int t = 1; t <= 12; t++) begin
      tick();
      check_all("mrst.db");
      check("mrst.lat", {8'h0, bus.rdata}, (t <= 10) ? 32'h0 : 32'h000F00);
    end

    // Randomised traffic against the model
    for (int i = 0; i < 400; i++) begin
      logic [7:0] a;
      int         r;
      r = $urandom_range(0, 4);
      case (r)
        0: a = 8'h60; 1: a = 8'h70; 2: a = 8'h80; 3: a = 8'h90;
        default: a = 8'($urandom);
      endcase
      set_bus(1'($urandom), 1'($urandom), a, 24'($urandom));
      reset = ($urandom_range(0, 99) < 2);
      if ($urandom_range(0, 99) < 6) sw_i = 24'($urandom);
      #1;
      check_all("rnd.pre");
      tick();
      check_all("rnd.post");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
